conv_engine: RTL and testbench

CONV_ENGINE -- requirements
Module: conv_engine

---
 rtl/conv_engine_if.sv | 28 ++
 rtl/conv_engine.sv | 142 ++++++++++++++
 tb/tb_conv_engine.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/conv_engine_if.sv
// Stream bundle for conv_engine: x and h sample inputs, y result output, busy flag.
// slave is the engine side, master is the producer/consumer side.
interface conv_engine_if #(
    parameter int DW = 8,
    parameter int OW = 16
);
    logic                 x_valid;
    logic                 x_ready;
    logic signed [DW-1:0] x_data;
    logic                 h_valid;
    logic                 h_ready;
    logic signed [DW-1:0] h_data;
    logic                 y_valid;
    logic                 y_ready;
    logic signed [OW-1:0] y_data;
    logic                 y_last;
    logic                 busy;

    modport slave (
        input  x_valid, x_data, h_valid, h_data, y_ready,
        output x_ready, h_ready, y_valid, y_data, y_last, busy
    );

    modport master (
        output x_valid, x_data, h_valid, h_data, y_ready,
        input  x_ready, h_ready, y_valid, y_data, y_last, busy
    );
endinterface

// File: rtl/conv_engine.sv
// 8x8 full linear convolution, one MAC per cycle, results streamed as y[0..14].
// Optional macro CONV_SAT_EN: saturate y to the OW range instead of wrapping.
module conv_engine #(
    parameter int DW = 8,
    parameter int OW = 16
) (
    input  logic          clk,
    input  logic          rstn,
    conv_engine_if.slave  bus
);
    localparam int N  = 8;
    localparam int AW = 2*DW + 3;

    typedef enum logic [1:0] {LOAD, MAC, OUT} state_t;

    state_t r_state, w_next;

    logic signed [DW-1:0] r_x [N];
    logic signed [DW-1:0] r_h [N];
    logic [3:0]           r_xcnt, r_hcnt, r_n;
    logic [2:0]           r_k;
    logic signed [AW-1:0] r_acc;

    logic                   w_x_ready, w_h_ready, w_y_valid;
    logic                   w_x_fire, w_h_fire, w_y_fire, w_loaded, w_last_term;
    logic [2:0]             w_kend, w_kstart_nxt, w_hidx;
    logic [3:0]             w_n_nxt;
    logic signed [2*DW-1:0] w_prod;
    logic signed [AW-1:0]   w_prod_ext;
    logic signed [OW-1:0]   w_y;

    assign w_x_fire    = bus.x_valid && w_x_ready;
    assign w_h_fire    = bus.h_valid && w_h_ready;
    assign w_y_fire    = w_y_valid && bus.y_ready;
    assign w_loaded    = (r_xcnt == 4'd8) && (r_hcnt == 4'd8);

    // Term window for y[n] is k = max(0,n-7) .. min(n,7); h index n-k always fits 3 bits.
    assign w_kend       = (r_n < 4'd7) ? r_n[2:0] : 3'd7;
    assign w_n_nxt      = r_n + 4'd1;
    assign w_kstart_nxt = (w_n_nxt > 4'd7) ? (w_n_nxt[2:0] + 3'd1) : 3'd0;
    assign w_last_term  = (r_k == w_kend);
    assign w_hidx       = r_n[2:0] - r_k;

    assign w_prod     = r_x[r_k] * r_h[w_hidx];
    assign w_prod_ext = {{(AW-2*DW){w_prod[2*DW-1]}}, w_prod};

    always_ff @(posedge clk) begin
        if (!rstn) r_state <= LOAD;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_x_ready = 1'b0;
        w_h_ready = 1'b0;
        w_y_valid = 1'b0;
        case (r_state)
            LOAD: begin
                w_x_ready = (r_xcnt < 4'd8);
                w_h_ready = (r_hcnt < 4'd8);
                if (w_loaded) w_next = MAC;
            end
            MAC: begin
                if (w_last_term) w_next = OUT;
            end
            OUT: begin
                w_y_valid = 1'b1;
                if (bus.y_ready) w_next = (r_n == 4'd14) ? LOAD : MAC;
            end
            default: w_next = LOAD;
        endcase
    end

    // Sample storage needs no reset: write indices gate what is ever read.
    always_ff @(posedge clk) begin
        if (r_state == LOAD) begin
            if (w_x_fire) r_x[r_xcnt[2:0]] <= bus.x_data;
            if (w_h_fire) r_h[r_hcnt[2:0]] <= bus.h_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_xcnt <= 4'd0;
            r_hcnt <= 4'd0;
            r_n    <= 4'd0;
            r_k    <= 3'd0;
            r_acc  <= '0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (w_x_fire) r_xcnt <= r_xcnt + 4'd1;
                    if (w_h_fire) r_hcnt <= r_hcnt + 4'd1;
                    if (w_loaded) begin
                        r_n   <= 4'd0;
                        r_k   <= 3'd0;
                        r_acc <= '0;
                    end
                end
                MAC: begin
                    r_acc <= r_acc + w_prod_ext;
                    if (!w_last_term) r_k <= r_k + 3'd1;
                end
                OUT: begin
                    if (w_y_fire) begin
                        r_acc <= '0;
                        if (r_n == 4'd14) begin
                            r_n    <= 4'd0;
                            r_k    <= 3'd0;
                            r_xcnt <= 4'd0;
                            r_hcnt <= 4'd0;
                        end else begin
                            r_n <= w_n_nxt;
                            r_k <= w_kstart_nxt;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CONV_SAT_EN
    localparam logic signed [AW-1:0] SMAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [AW-1:0] SMIN = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    always_comb begin
        w_y = r_acc[OW-1:0];
        if (r_acc > SMAX)      w_y = SMAX[OW-1:0];
        else if (r_acc < SMIN) w_y = SMIN[OW-1:0];
    end
`else
    assign w_y = r_acc[OW-1:0];
`endif

    assign bus.x_ready = w_x_ready;
    assign bus.h_ready = w_h_ready;
    assign bus.y_valid = w_y_valid;
    assign bus.y_data  = w_y;
    assign bus.y_last  = w_y_valid && (r_n == 4'd14);
    assign bus.busy    = (r_state != LOAD);
endmodule

// File: tb/tb_conv_engine.sv
// Directed bench for conv_engine: table of x/h/y vectors plus stall and mid-run reset sequences.
module tb_conv_engine;
    localparam int DW = 8;
    localparam int OW = 16;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    conv_engine_if #(.DW(DW), .OW(OW)) bus();

    conv_engine #(.DW(DW), .OW(OW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    // y holds the full-precision sum; to_out maps it to the OW-bit output.
    typedef struct packed {
        logic [0:7][7:0]   x;
        logic [0:7][7:0]   h;
        logic [0:14][31:0] y;
    } vec_t;

    vec_t tbl [4];
    int   nvec   = 0;
    int   nerr   = 0;
    int   rd_bad = 0;
    int   macc;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int to_out(input logic [31:0] full);
        logic signed [31:0] f;
        logic signed [15:0] w;
        f = full;
        w = f[15:0];
`ifdef CONV_SAT_EN
        if (f > 32767)  return 32767;
        if (f < -32768) return -32768;
        return int'(w);
`else
        return int'(w);
`endif
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_y_valid"}, int'(bus.y_valid), 0);
        chk({tag, "_y_last"},  int'(bus.y_last),  0);
        chk({tag, "_y_data"},  int'($signed(bus.y_data)), 0);
        chk({tag, "_busy"},    int'(bus.busy),    0);
        chk({tag, "_x_ready"}, int'(bus.x_ready), 1);
        chk({tag, "_h_ready"}, int'(bus.h_ready), 1);
    endtask

    // h stream starts hskew cycles after x, so x_ready must drop first.
    task automatic load_vec(input int v, input int hskew);
        int   xi, hi, cyc;
        logic fx, fh;
        xi = 0; hi = 0; cyc = 0;
        while ((xi < 8 || hi < 8) && cyc < 40) begin
            @(negedge clk);
            bus.x_valid = (xi < 8);
            bus.x_data  = tbl[v].x[xi & 7];
            bus.h_valid = (hi < 8) && (cyc >= hskew);
            bus.h_data  = tbl[v].h[hi & 7];
            if (xi == 8 && hi < 8) chk("x_ready_after_8", int'(bus.x_ready), 0);
            fx = bus.x_valid && bus.x_ready;
            fh = bus.h_valid && bus.h_ready;
            @(posedge clk);
            if (fx) xi++;
            if (fh) hi++;
            cyc++;
        end
        chk("load_accepted", xi + hi, 16);
    endtask

    // Junk is held on x/h valid throughout the run; the engine must ignore it.
    task automatic take_beats(input int v, input int first, input int last,
                              input int stall_n, output int mac_cyc);
        int waited;
        int exp_y;
        mac_cyc = 0;
        rd_bad  = 0;
        for (int n = first; n <= last; n++) begin
            waited = 0;
            @(negedge clk);
            bus.x_valid = 1'b1; bus.x_data = 8'h55;
            bus.h_valid = 1'b1; bus.h_data = 8'h55;
            while (!bus.y_valid && waited < 20) begin
                if (bus.busy) begin
                    mac_cyc++;
                    if (bus.x_ready || bus.h_ready) rd_bad++;
                end
                waited++;
                @(negedge clk);
            end
            if (!bus.y_valid) begin
                chk($sformatf("y[%0d]_timeout", n), 0, 1);
                continue;
            end
            exp_y = to_out(tbl[v].y[n]);
            chk($sformatf("v%0d_y[%0d]", v, n), int'($signed(bus.y_data)), exp_y);
            chk($sformatf("v%0d_y_last[%0d]", v, n), int'(bus.y_last), (n == 14) ? 1 : 0);
            if (n == 14) begin
                bus.x_valid = 1'b0;
                bus.h_valid = 1'b0;
            end
            if (n == stall_n) begin
                bus.y_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    chk("stall_y_valid", int'(bus.y_valid), 1);
                    chk("stall_y_hold", int'($signed(bus.y_data)), exp_y);
                end
                bus.y_ready = 1'b1;
            end
        end
        chk("ready_low_in_run", rd_bad, 0);
    endtask

    task automatic chk_idle();
        @(negedge clk);
        chk("idle_busy",    int'(bus.busy),    0);
        chk("idle_y_valid", int'(bus.y_valid), 0);
        chk("idle_x_ready", int'(bus.x_ready), 1);
    endtask

    initial begin
        int stray;

        tbl[0].x = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        tbl[0].h = {8{8'd1}};
        tbl[0].y = {32'd1, 32'd3, 32'd6, 32'd10, 32'd15, 32'd21, 32'd28, 32'd36,
                    32'd35, 32'd33, 32'd30, 32'd26, 32'd21, 32'd15, 32'd8};

        tbl[1].x = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        tbl[1].h = {8'd1, {7{8'd0}}};
        tbl[1].y = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, {7{32'd0}}};

        tbl[2].x = {8{8'd127}};
        tbl[2].h = {8{8'd127}};
        tbl[2].y = {32'd16129, 32'd32258, 32'd48387, 32'd64516, 32'd80645, 32'd96774,
                    32'd112903, 32'd129032, 32'd112903, 32'd96774, 32'd80645, 32'd64516,
                    32'd48387, 32'd32258, 32'd16129};

        tbl[3].x = {8{8'h80}};
        tbl[3].h = {8{8'd127}};
        tbl[3].y = {-32'sd16256, -32'sd32512, -32'sd48768, -32'sd65024, -32'sd81280,
                    -32'sd97536, -32'sd113792, -32'sd130048, -32'sd113792, -32'sd97536,
                    -32'sd81280, -32'sd65024, -32'sd48768, -32'sd32512, -32'sd16256};

        bus.x_valid = 1'b0; bus.x_data = '0;
        bus.h_valid = 1'b0; bus.h_data = '0;
        bus.y_ready = 1'b1;

        rstn = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rstn = 1'b1;

        for (int v = 0; v < 4; v++) begin
            load_vec(v, v);
            take_beats(v, 0, 14, -1, macc);
            chk($sformatf("v%0d_mac_cycles", v), macc, 64);
            chk_idle();
        end

        // Backpressure on y[3] for five cycles.
        load_vec(0, 0);
        take_beats(0, 0, 14, 3, macc);
        chk("stall_mac_cycles", macc, 64);
        chk_idle();

        // Reset while accumulating y[5]; the run must be abandoned.
        load_vec(0, 2);
        take_beats(0, 0, 4, -1, macc);
        @(negedge clk);
        chk("abort_in_mac", int'(bus.busy && !bus.y_valid), 1);
        rstn = 1'b0;
        bus.x_valid = 1'b0;
        bus.h_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk_reset_outputs("midrun_reset");
        stray = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.y_valid || bus.busy) stray++;
        end
        chk("no_stale_beat", stray, 0);
        load_vec(0, 0);
        take_beats(0, 0, 14, -1, macc);
        chk("post_reset_mac_cycles", macc, 64);
        chk_idle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
